// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths, initiator FSM states,
// and command/response records.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = WB_DAT_W / 8;

  // state | meaning
  // IDLE  | waiting for a command; cmd_ready high
  // BUS   | Wishbone cycle in progress; cyc/stb high, waiting for ack or timeout
  // RESP  | response presented; rsp_valid high until rsp_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                we;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter. Flags expiry once TIMEOUT-1 enabled cycles have
// been counted since the last clear, then holds there instead of wrapping.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
)(
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LP_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_count;

  // Count enabled cycles; clear has priority, stop at the terminal value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LP_LAST)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = (r_count == LP_LAST);

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator with valid/ready command and
// response channels and an ack timeout.
module wb_host_master
  import wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DAT_W / 8
)(
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [DAT_W-1:0] wbm_dat_i
);

  wb_state_e r_state;
  wb_state_e w_next;

  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [DAT_W-1:0] r_rsp_dat;
  logic             r_rsp_err;
  logic             r_cyc;
  logic             r_we;
  logic [ADR_W-1:0] r_adr;
  logic [DAT_W-1:0] r_dat;
  logic [SEL_W-1:0] r_sel;

  logic w_accept;
  logic w_ack;
  logic w_timeout;
  logic w_expired;

  // r_cmd_ready is only high in IDLE, and stays low for the first cycle out
  // of reset, so it doubles as the accept qualifier.
  assign w_accept  = r_cmd_ready && cmd_valid;
  assign w_ack     = (r_state == BUS) && wbm_ack_i;
  assign w_timeout = (r_state == BUS) && !wbm_ack_i && w_expired;

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (wb_clk_i),
    .i_rst_b   (wb_rst_i),
    .i_clr     (w_accept),
    .i_en      ((r_state == BUS) && !wbm_ack_i),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; an ack in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = BUS;
      BUS:  if (w_ack || w_timeout) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs: handshake/strobe flags follow the next state, bus
  // fields load on accept, response fields load on ack or timeout.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
    end else begin
      r_cmd_ready <= (w_next == IDLE);
      r_rsp_valid <= (w_next == RESP);
      r_cyc       <= (w_next == BUS);
      if (w_accept) begin
        r_we  <= cmd_we;
        r_adr <= cmd_adr;
        r_dat <= cmd_dat;
        r_sel <= cmd_sel;
      end
      if (w_ack) begin
        r_rsp_dat <= r_we ? '0 : wbm_dat_i;
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_dat <= '0;
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign wbm_sel_o = r_sel;

endmodule
